// File: rtl/sprite_stream_arbiter.sv
// Two-source sprite record merger: per-source FIFOs drained round-robin
// into one registered ready/valid stream, resynchronised on new_frame.

module sprite_fifo #(
    parameter int W     = 21,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         empty,
    output logic [W-1:0] head,
    output logic [7:0]   drops
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW-1:0] waddr;
    logic          full;
    logic          do_pop;
    logic          do_push;
    logic          drop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    // A flush empties the FIFO first, so that cycle's record always fits.
    assign do_push = push && (flush || !full || do_pop);
    assign drop    = push && !flush && full && !do_pop;
    assign waddr   = flush ? '0 : wr_ptr[AW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            drops  <= '0;
        end else begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= do_push ? ONE : '0;
            end else begin
                if (do_pop)  rd_ptr <= rd_ptr + ONE;
                if (do_push) wr_ptr <= wr_ptr + ONE;
            end
            if (drop && drops != 8'hff) drops <= drops + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[waddr] <= din;
    end
endmodule

module sprite_stream_arbiter #(
    parameter int CANVAS_WIDTH  = 100,
    parameter int CANVAS_HEIGHT = 100,
    parameter int NUM_FRAMES    = 100,
    parameter int FIFO_DEPTH    = 4,
    localparam int XW = $clog2(CANVAS_WIDTH),
    localparam int YW = $clog2(CANVAS_HEIGHT),
    localparam int FW = $clog2(NUM_FRAMES)
) (
    input  logic          pixel_clk_in,
    input  logic          rst_in,
    input  logic          new_frame,
    input  logic [XW-1:0] s0_x,
    input  logic [YW-1:0] s0_y,
    input  logic [FW-1:0] s0_frame,
    input  logic          s0_valid,
    input  logic [XW-1:0] s1_x,
    input  logic [YW-1:0] s1_y,
    input  logic [FW-1:0] s1_frame,
    input  logic          s1_valid,
    output logic [XW-1:0] out_x,
    output logic [YW-1:0] out_y,
    output logic [FW-1:0] out_frame,
    output logic          out_src,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    drop0,
    output logic [7:0]    drop1,
    output logic [7:0]    last_count
);
    localparam int RW = XW + YW + FW;

    logic [RW-1:0] head0;
    logic [RW-1:0] head1;
    logic [RW-1:0] head_g;
    logic          empty0;
    logic          empty1;
    logic          load;
    logic          gnt;
    logic          pop0;
    logic          pop1;
    logic          deliver;
    logic          prio;
    logic [7:0]    cnt;

    assign load    = (!out_valid || out_ready) && !(empty0 && empty1);
    // Favour the prio source, fall back to whichever one has data.
    assign gnt     = prio ? !empty1 : empty0;
    assign pop0    = load && !gnt;
    assign pop1    = load && gnt;
    assign head_g  = gnt ? head1 : head0;
    assign deliver = out_valid && out_ready;

    sprite_fifo #(.W(RW), .DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clk   (pixel_clk_in),
        .rst   (rst_in),
        .flush (new_frame),
        .push  (s0_valid),
        .din   ({s0_x, s0_y, s0_frame}),
        .pop   (pop0),
        .empty (empty0),
        .head  (head0),
        .drops (drop0)
    );

    sprite_fifo #(.W(RW), .DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk   (pixel_clk_in),
        .rst   (rst_in),
        .flush (new_frame),
        .push  (s1_valid),
        .din   ({s1_x, s1_y, s1_frame}),
        .pop   (pop1),
        .empty (empty1),
        .head  (head1),
        .drops (drop1)
    );

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_frame <= '0;
            out_src   <= 1'b0;
            prio      <= 1'b0;
        end else if (new_frame) begin
            out_valid <= 1'b0;
            prio      <= 1'b0;
        end else if (load) begin
            {out_x, out_y, out_frame} <= head_g;
            out_src   <= gnt;
            out_valid <= 1'b1;
            prio      <= !gnt;
        end else if (deliver) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            cnt        <= '0;
            last_count <= '0;
        end else if (new_frame) begin
            // A delivery on the boundary cycle still belongs to the old frame.
            last_count <= (deliver && cnt != 8'hff) ? cnt + 8'd1 : cnt;
            cnt        <= '0;
        end else if (deliver && cnt != 8'hff) begin
            cnt <= cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_sprite_stream_arbiter.sv
// Directed bench for sprite_stream_arbiter: round-robin, back-pressure,
// overflow, frame boundary, drop saturation and mid-stream reset.

module tb_sprite_stream_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic       new_frame;
    logic [6:0] s0_x, s0_y, s0_frame;
    logic       s0_valid;
    logic [6:0] s1_x, s1_y, s1_frame;
    logic       s1_valid;
    logic [6:0] out_x, out_y, out_frame;
    logic       out_src;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] drop0, drop1, last_count;

    int total = 0;
    int bad   = 0;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    sprite_stream_arbiter dut (
        .pixel_clk_in (clk),
        .rst_in       (rst),
        .new_frame    (new_frame),
        .s0_x         (s0_x),
        .s0_y         (s0_y),
        .s0_frame     (s0_frame),
        .s0_valid     (s0_valid),
        .s1_x         (s1_x),
        .s1_y         (s1_y),
        .s1_frame     (s1_frame),
        .s1_valid     (s1_valid),
        .out_x        (out_x),
        .out_y        (out_y),
        .out_frame    (out_frame),
        .out_src      (out_src),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .drop0        (drop0),
        .drop1        (drop1),
        .last_count   (last_count)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Log any delivery happening at the coming edge, then advance one cycle.
    task automatic step();
        if (out_valid && out_ready) q.push_back({out_src, out_x});
        @(negedge clk);
    endtask

    task automatic set0(input logic v, input logic [6:0] x);
        s0_valid = v;
        s0_x = x;
        s0_y = x + 7'd1;
        s0_frame = x + 7'd2;
    endtask

    task automatic set1(input logic v, input logic [6:0] x);
        s1_valid = v;
        s1_x = x;
        s1_y = x + 7'd1;
        s1_frame = x + 7'd2;
    endtask

    initial begin
        rst = 1'b1;
        new_frame = 1'b0;
        out_ready = 1'b0;
        set0(1'b0, 7'd0);
        set1(1'b0, 7'd0);
        repeat (2) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_x", out_x, 0);
        check("rst_src", out_src, 0);
        check("rst_drops", {drop0, drop1}, 0);
        check("rst_last", last_count, 0);
        rst = 1'b0;
        step();

        // round-robin with both sources pushing together
        out_ready = 1'b1;
        q.delete();
        for (int i = 0; i < 3; i++) begin
            set0(1'b1, 7'(10 + i));
            set1(1'b1, 7'(20 + i));
            step();
            if (i == 0) check("lat_t1", out_valid, 0);
            if (i == 1) begin
                check("lat_t2", out_valid, 1);
                check("lat_src", out_src, 0);
            end
        end
        set0(1'b0, 7'd0);
        set1(1'b0, 7'd0);
        repeat (7) step();
        check("rr_count", q.size(), 6);
        for (int k = 0; k < 6; k++)
            check($sformatf("rr_%0d", k), q[k],
                  (k % 2) ? {1'b1, 7'(20 + k / 2)} : {1'b0, 7'(10 + k / 2)});
        check("rr_drops", {drop0, drop1}, 0);

        // back-pressure: 7 records into a stalled output
        out_ready = 1'b0;
        q.delete();
        for (int i = 0; i < 7; i++) begin
            set0(1'b1, 7'(40 + i));
            step();
            if (i == 0) check("bp_idle", out_valid, 0);
            else begin
                check($sformatf("bp_hold_%0d", i),
                      {out_valid, out_src, out_x, out_y, out_frame},
                      {1'b1, 1'b0, 7'd40, 7'd41, 7'd42});
            end
        end
        set0(1'b0, 7'd0);
        step();
        check("bp_drop0", drop0, 2);
        out_ready = 1'b1;
        repeat (7) step();
        check("bp_count", q.size(), 5);
        for (int k = 0; k < 5; k++)
            check($sformatf("bp_ord_%0d", k), q[k], {1'b0, 7'(40 + k)});

        // full FIFO: push and pop in the same cycle
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set0(1'b1, 7'(60 + i));
            step();
        end
        q.delete();
        set0(1'b1, 7'd65);
        out_ready = 1'b1;
        step();
        set0(1'b0, 7'd0);
        check("full_drop0", drop0, 2);
        repeat (8) step();
        check("full_count", q.size(), 6);
        for (int k = 0; k < 6; k++)
            check($sformatf("full_ord_%0d", k), q[k], {1'b0, 7'(60 + k)});

        // close the running frame: 6 + 5 + 6 deliveries so far
        new_frame = 1'b1;
        step();
        new_frame = 1'b0;
        check("frame0_last", last_count, 17);

        // frame boundary with records queued and a same-cycle s1 record
        for (int i = 0; i < 5; i++) begin
            set0(1'b1, 7'(70 + i));
            step();
        end
        set0(1'b0, 7'd0);
        repeat (3) step();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set0(1'b1, 7'(80 + i));
            step();
        end
        set0(1'b0, 7'd0);
        step();
        check("nf_pre_valid", out_valid, 1);
        new_frame = 1'b1;
        set1(1'b1, 7'd90);
        step();
        new_frame = 1'b0;
        set1(1'b0, 7'd0);
        check("nf_last", last_count, 5);
        check("nf_valid", out_valid, 0);
        out_ready = 1'b1;
        q.delete();
        repeat (6) step();
        check("nf_count", q.size(), 1);
        check("nf_rec", q[0], {1'b1, 7'd90});

        // drop-counter saturation on source 1
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 205; i++) begin
            set1(1'b1, 7'(i % 100));
            step();
        end
        check("sat_mid", drop1, 200);
        for (int i = 0; i < 100; i++) step();
        set1(1'b0, 7'd0);
        step();
        check("sat_drop1", drop1, 255);
        check("sat_drop0", drop0, 0);

        // mid-stream reset with output held and both FIFOs occupied
        for (int i = 0; i < 2; i++) begin
            set0(1'b1, 7'(100 + i));
            step();
        end
        set0(1'b0, 7'd0);
        check("mr_pre_valid", out_valid, 1);
        rst = 1'b1;
        step();
        check("mr_valid", out_valid, 0);
        check("mr_out", {out_src, out_x, out_y, out_frame}, 0);
        check("mr_cnts", {drop0, drop1, last_count}, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        q.delete();
        repeat (8) step();
        check("mr_stale", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sprite_stream_arbiter.md
# sprite_stream_arbiter

Merges the sprite-record streams of two `singleprocessor` instances (one per player) into a single ready/valid stream for the renderer. Each processor emits fire-and-forget records (`x`, `y`, `frame`, `sprite_valid`) with no back-pressure, so each source gets a small FIFO. A round-robin arbiter drains the FIFOs into one registered output. The block resynchronises on every `new_frame`, counts dropped records per source, and reports how many sprites were delivered in the last frame.

## Interface
Parameters:
- `CANVAS_WIDTH`, default 100: sprite x range; `XW = $clog2(CANVAS_WIDTH)`.
- `CANVAS_HEIGHT`, default 100: sprite y range; `YW = $clog2(CANVAS_HEIGHT)`.
- `NUM_FRAMES`, default 100: animation frame range; `FW = $clog2(NUM_FRAMES)`.
- `FIFO_DEPTH`, default 4: entries per source FIFO; must be a power of 2, ≥2.

Ports:
- `pixel_clk_in`, in, 1: the single clock.
- `rst_in`, in, 1: synchronous, active-high reset.
- `new_frame`, in, 1: one-cycle frame-boundary pulse, shared with the processors.
- `s0_x` / `s0_y` / `s0_frame`, in, XW/YW/FW: source-0 sprite record.
- `s0_valid`, in, 1: source-0 record present this cycle.
- `s1_x` / `s1_y` / `s1_frame` / `s1_valid`: source 1, same as source 0.
- `out_x` / `out_y` / `out_frame`, out, XW/YW/FW: granted record.
- `out_src`, out, 1: source index of the current output record.
- `out_valid`, out, 1: output record valid.
- `out_ready`, in, 1: renderer accepts the record.
- `drop0`, `drop1`, out, 8: per-source dropped-record counters; saturate at 255.
- `last_count`, out, 8: records delivered in the previous frame; saturates at 255.

## Operation
- Each source has one FIFO of `FIFO_DEPTH` entries, `XW+YW+FW` bits wide.
  - Push when `sN_valid` is high.
  - If the FIFO is full and no pop happens that cycle, drop the record and increment `dropN`, saturating at 255.
  - A push and a pop in the same cycle on a full FIFO are both accepted.
- Output register load condition: `(!out_valid || out_ready)` and at least one FIFO is non-empty.
- Grant rule:
  - Grant the source named by the priority bit `prio` if it is non-empty; otherwise grant the other source.
  - After a grant, `prio` becomes the complement of the granted source.
- The loaded record goes to `out_*`, with `out_src` set to the granted source. The granted FIFO pops in the same cycle.
- Output hold rule: while `out_valid && !out_ready`, all `out_*` signals are held stable. Only `new_frame` may break this.
- A delivery is a cycle with `out_valid && out_ready`. The frame counter `cnt` increments on each delivery, saturating at 255.
- On the `new_frame` cycle, the following values apply from the next cycle:
  - Both FIFOs are flushed.
  - `out_valid` = 0 and `prio` = 0.
  - `last_count` = `cnt`, plus 1 if a delivery also occurs in that cycle.
  - `cnt` = 0.
- Records presented on `sN_valid` in the `new_frame` cycle are not lost: they are enqueued into the emptied FIFOs and belong to the new frame.
- A delivery in the `new_frame` cycle counts toward the old frame.
- The drop counters are not cleared by `new_frame`; only `rst_in` clears them.
- Reset values: FIFOs empty, `out_valid` = 0, `out_x` = `out_y` = `out_frame` = 0, `out_src` = 0, `prio` = 0, `drop0` = `drop1` = 0, `cnt` = 0, `last_count` = 0.
- Reset asserted mid-operation discards everything in flight. No output is driven in the reset cycle or in the cycle after it.

## Timing
- Latency: with an idle output and empty FIFOs, `sN_valid` at cycle t gives `out_valid` at t+2. There is no bypass path.
- Throughput: 1 record per cycle while `out_ready` = 1. Sustained input of 2 records per cycle will drop once the FIFOs fill.
- FIFO state registers update at the clock edge. Fullness is evaluated on pre-edge occupancy together with the same-cycle pop.
- `new_frame` has priority over every other update in its cycle, except the enqueue of that cycle's inputs and the `last_count` capture.
- `rst_in` has priority over `new_frame`.
- Pointer arithmetic is modulo `FIFO_DEPTH`. Occupancy is tracked with an extra wrap bit, so full and empty are distinguishable.

## Test plan
- **Round-robin:** after reset, hold `out_ready` = 1 and pulse `s0_valid` and `s1_valid` together for 3 cycles. Required: 6 outputs with `out_src` = 0,1,0,1,0,1; the first `out_valid` appears 2 cycles after the first push; `drop0` = `drop1` = 0.
- **Back-pressure and overflow:** set `out_ready` = 0 and send 7 records on source 0 (FIFO_DEPTH = 4). Required:
  - The first record sits in the output register with all `out_*` stable.
  - The next 4 records fill the FIFO; the remaining 2 are dropped, so `drop0` = 2.
  - After raising `out_ready`, the first 5 records come out in order.
- **Full FIFO with simultaneous push and pop:** with the source-0 FIFO full and `out_ready` = 1, push one record. Required: the push is accepted and `drop0` is unchanged.
- **Frame boundary:** deliver 5 records, then pulse `new_frame` while 3 records are queued and `s1_valid` = 1 in the same cycle. Required:
  - `last_count` = 5 on the next cycle and `out_valid` = 0.
  - Only the `s1` record from the `new_frame` cycle appears afterwards, with `out_src` = 1.
- **Saturation:** force 300 drops on source 1. Required: `drop1` = 255 and `drop0` = 0.
- **Mid-stream reset:** assert `rst_in` while `out_valid` = 1 and both FIFOs are non-empty. Required: all outputs at their reset values the next cycle, and no stale record ever appears afterwards.
